// File: rtl/game_pkg.sv
// Shared game-round definitions: state encoding and spawn-interval lookup
// used by the scheduler, spawner and display blocks.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAY      = 2'd2,
        ST_OVER      = 2'd3
    } game_state_e;

    function automatic int unsigned spawn_cycles(
        input logic [1:0]  lvl,
        input int unsigned c0,
        input int unsigned c1,
        input int unsigned c2,
        input int unsigned c3
    );
        case (lvl)
            2'd0:    return c0;
            2'd1:    return c1;
            2'd2:    return c2;
            default: return c3;
        endcase
    endfunction

    function automatic int unsigned max_cycles(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d,
        input int unsigned e
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Enable-gated, clearable prescaler with a runtime period and a registered
// one-cycle tick; term is exposed so the owner can act on the same edge.
module game_tick_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             mask,
    input  logic [CNT_W-1:0] period,
    output logic             term,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    assign term = en && (cnt == period - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= term && !mask;
            // Clear has priority so a wrap on the entry edge still restarts at 0
            if (clr)
                cnt <= '0;
            else if (en)
                cnt <= term ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_round_scheduler.sv
// Game round sequencer: IDLE -> countdown -> timed PLAY -> OVER, with a 1 s
// enable timebase and a level-dependent zombie-spawn strobe.
module game_round_scheduler
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 125000000,
    parameter int unsigned ROUND_SEC     = 60,
    parameter int unsigned COUNTDOWN_SEC = 3,
    parameter int unsigned SPAWN_CYC_L0  = 125000000,
    parameter int unsigned SPAWN_CYC_L1  = 93750000,
    parameter int unsigned SPAWN_CYC_L2  = 62500000,
    parameter int unsigned SPAWN_CYC_L3  = 31250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic [1:0] level,
    output logic [1:0] state,
    output logic       sec_tick,
    output logic       spawn_tick,
    output logic [1:0] countdown,
    output logic [6:0] time_left,
    output logic       game_over
);

    localparam int unsigned MAX_CYC = max_cycles(CLK_HZ, SPAWN_CYC_L0, SPAWN_CYC_L1,
                                                 SPAWN_CYC_L2, SPAWN_CYC_L3);
    localparam int CNT_W = $clog2(MAX_CYC);

    game_state_e      state_q, state_n;
    logic [1:0]       cd_q, cd_n;
    logic [6:0]       tl_q, tl_n;
    logic [1:0]       lvl_q, lvl_n;
    logic             over_q;

    logic             run;
    logic             sec_term, spawn_term;
    logic             sec_clr, spawn_clr, spawn_en, spawn_mask;
    logic [CNT_W-1:0] sec_period, spawn_period;

    assign run          = ((state_q == ST_COUNTDOWN) || (state_q == ST_PLAY)) && !pause;
    assign sec_period   = CNT_W'(CLK_HZ);
    assign spawn_period = CNT_W'(spawn_cycles(lvl_q, SPAWN_CYC_L0, SPAWN_CYC_L1,
                                              SPAWN_CYC_L2, SPAWN_CYC_L3));
    assign spawn_en     = run && (state_q == ST_PLAY);
    assign spawn_clr    = abort || (state_q != ST_PLAY);
    // A spawn landing on the round-ending second would show up in OVER
    assign spawn_mask   = abort || (sec_term && (state_q == ST_PLAY) && (tl_q == 7'd1));

    game_tick_gen #(.CNT_W(CNT_W)) u_sec_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (run),
        .clr    (sec_clr),
        .mask   (abort),
        .period (sec_period),
        .term   (sec_term),
        .tick   (sec_tick)
    );

    game_tick_gen #(.CNT_W(CNT_W)) u_spawn_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (spawn_en),
        .clr    (spawn_clr),
        .mask   (spawn_mask),
        .period (spawn_period),
        .term   (spawn_term),
        .tick   (spawn_tick)
    );

    always_comb begin
        state_n = state_q;
        cd_n    = cd_q;
        tl_n    = tl_q;
        lvl_n   = lvl_q;
        sec_clr = abort;
        if (abort) begin
            state_n = ST_IDLE;
            cd_n    = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_n = ST_COUNTDOWN;
                        cd_n    = 2'(COUNTDOWN_SEC);
                        tl_n    = 7'(ROUND_SEC);
                        lvl_n   = level;
                        sec_clr = 1'b1;
                    end
                end
                ST_COUNTDOWN: begin
                    if (sec_term) begin
                        if (cd_q == 2'd1) begin
                            cd_n    = 2'd0;
                            state_n = ST_PLAY;
                            sec_clr = 1'b1;
                        end else begin
                            cd_n = cd_q - 2'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (sec_term) begin
                        if (tl_q == 7'd1) begin
                            tl_n    = 7'd0;
                            state_n = ST_OVER;
                        end else begin
                            tl_n = tl_q - 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cd_q    <= 2'd0;
            tl_q    <= 7'd0;
            lvl_q   <= 2'd0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cd_q    <= cd_n;
            tl_q    <= tl_n;
            lvl_q   <= lvl_n;
            over_q  <= (state_n == ST_OVER);
        end
    end

    assign state      = state_q;
    assign countdown  = cd_q;
    assign time_left  = tl_q;
    assign game_over  = over_q;

    logic unused_term;
    assign unused_term = spawn_term;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Directed bench for game_round_scheduler with a cycle-stamped tick scoreboard.
module tb_game_round_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       pause;
    logic [1:0] level;
    logic [1:0] state;
    logic       sec_tick;
    logic       spawn_tick;
    logic [1:0] countdown;
    logic [6:0] time_left;
    logic       game_over;

    game_round_scheduler #(
        .CLK_HZ        (10),
        .ROUND_SEC     (5),
        .COUNTDOWN_SEC (3),
        .SPAWN_CYC_L0  (8),
        .SPAWN_CYC_L1  (6),
        .SPAWN_CYC_L2  (4),
        .SPAWN_CYC_L3  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .level      (level),
        .state      (state),
        .sec_tick   (sec_tick),
        .spawn_tick (spawn_tick),
        .countdown  (countdown),
        .time_left  (time_left),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int t0   = 0;
    int ps   = 0;
    int pl   = 0;
    int lvl_chg_at = -1;
    int exp_sec_q[$];
    int exp_spawn_q[$];

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Active (unpaused) cycle offset from countdown entry -> absolute cycle
    function automatic int abs_of(input int a);
        if (pl == 0 || t0 + a <= ps) return t0 + a;
        return t0 + a + pl;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (sec_tick === 1'b1) begin
            if (exp_sec_q.size() == 0) chk("sec_tick_unexpected", cyc, -1);
            else chk("sec_tick_cycle", cyc, exp_sec_q.pop_front());
        end
        if (spawn_tick === 1'b1) begin
            if (exp_spawn_q.size() == 0) chk("spawn_tick_unexpected", cyc, -1);
            else chk("spawn_tick_cycle", cyc, exp_spawn_q.pop_front());
        end
    endtask

    task automatic push_round(input int per, input int cut);
        for (int a = 10; a <= 80; a += 10)
            if (abs_of(a) < cut) exp_sec_q.push_back(abs_of(a));
        for (int a = 30 + per; a < 80; a += per)
            if (abs_of(a) < cut) exp_spawn_q.push_back(abs_of(a));
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
        chk("start_state", 32'(state), 1);
        chk("start_countdown", 32'(countdown), 3);
        chk("start_time_left", 32'(time_left), 5);
        chk("start_game_over", 32'(game_over), 0);
    endtask

    task automatic wait_over();
        int limit = 300;
        int saved_tl = 0;
        while (state !== 2'd3 && limit > 0) begin
            pause = (pl > 0 && cyc >= ps && cyc < ps + pl);
            if (cyc == lvl_chg_at) level = 2'd3;
            step();
            limit--;
            if (cyc == abs_of(10)) chk("countdown_2", 32'(countdown), 2);
            if (cyc == abs_of(20)) chk("countdown_1", 32'(countdown), 1);
            if (cyc == abs_of(30)) begin
                chk("countdown_0", 32'(countdown), 0);
                chk("play_entry", 32'(state), 2);
            end
            if (pl > 0 && cyc == ps) saved_tl = 32'(time_left);
            if (pl > 0 && cyc > ps && cyc <= ps + pl)
                chk("time_left_paused", 32'(time_left), saved_tl);
        end
        pause = 1'b0;
        chk("over_cycle", cyc, abs_of(80));
        chk("time_left_end", 32'(time_left), 0);
        chk("game_over", 32'(game_over), 1);
        chk("spawn_in_over", 32'(spawn_tick), 0);
        repeat (3) step();
        chk("sec_missing", exp_sec_q.size(), 0);
        chk("spawn_missing", exp_spawn_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; abort = 1'b0; pause = 1'b0; level = 2'd0;
        repeat (3) step();
        chk("rst_state", 32'(state), 0);
        chk("rst_countdown", 32'(countdown), 0);
        chk("rst_time_left", 32'(time_left), 0);
        chk("rst_sec_tick", 32'(sec_tick), 0);
        chk("rst_spawn_tick", 32'(spawn_tick), 0);
        chk("rst_game_over", 32'(game_over), 0);
        rst = 1'b1; start = 1'b0;
        step();
        chk("idle_after_rst", 32'(state), 0);

        // Full round at level 2
        level = 2'd2;
        do_start();
        push_round(4, 1 << 30);
        wait_over();

        // Restart from OVER at level 3: final-second spawn collision
        level = 2'd3;
        do_start();
        push_round(2, 1 << 30);
        wait_over();

        // Pause 17 cycles mid-PLAY
        level = 2'd2;
        do_start();
        ps = t0 + 55;
        pl = 17;
        push_round(4, 1 << 30);
        wait_over();
        pl = 0;

        // Level change during PLAY is ignored
        level = 2'd0;
        do_start();
        lvl_chg_at = t0 + 45;
        push_round(8, 1 << 30);
        wait_over();
        lvl_chg_at = -1;

        // Start ignored in PLAY, then abort+start together
        level = 2'd2;
        do_start();
        push_round(4, t0 + 46);
        while (cyc < t0 + 45) begin
            start = (cyc == t0 + 35);
            step();
        end
        start = 1'b0;
        chk("start_ignored_play", 32'(state), 2);
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        chk("abort_state", 32'(state), 0);
        chk("abort_countdown", 32'(countdown), 0);
        chk("abort_time_left_held", 32'(time_left), 4);
        repeat (20) step();
        chk("abort_stays_idle", 32'(state), 0);
        chk("abort_sec_missing", exp_sec_q.size(), 0);
        chk("abort_spawn_missing", exp_spawn_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/game_round_scheduler.md
Name: game_round_scheduler

Overview:
- Sequences one game round: IDLE → 3-2-1 countdown → timed PLAY → OVER.
- Generates a 1 s timebase and a level-dependent zombie-spawn strobe from the system clock.
- Sits between the button/UI front end and the zombie spawner, score and display blocks.
- Supplies a single-cycle enable timebase, not a divided clock.

Parameters:
- CLK_HZ, 125000000, clock cycles per game second.
- ROUND_SEC, 60, PLAY duration in seconds; range 1..127.
- COUNTDOWN_SEC, 3, pre-play countdown in seconds; range 1..3.
- SPAWN_CYC_L0, 125000000, spawn interval in cycles at level 0.
- SPAWN_CYC_L1, 93750000, spawn interval in cycles at level 1.
- SPAWN_CYC_L2, 62500000, spawn interval in cycles at level 2.
- SPAWN_CYC_L3, 31250000, spawn interval in cycles at level 3.
- All SPAWN_CYC_* values are ≥ 2.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  pulse: begin or restart a round.
- abort  in  1  pulse: return to IDLE from any state.
- pause  in  1  level: freezes all timing while in COUNTDOWN or PLAY.
- level  in  2  difficulty, selects SPAWN_CYC_Lx.
- state  out  2  0=IDLE, 1=COUNTDOWN, 2=PLAY, 3=OVER.
- sec_tick  out  1  one-cycle strobe each elapsed game second.
- spawn_tick  out  1  one-cycle spawn request.
- countdown  out  2  countdown seconds remaining.
- time_left  out  7  PLAY seconds remaining.
- game_over  out  1  high while state==OVER.

Behaviour:
- Reset (rst==0 at a clk edge) values: state=IDLE, countdown=0, time_left=0, sec_tick=0, spawn_tick=0, game_over=0, both internal counters=0. Reset mid-round aborts immediately.
- All outputs are registered. There is no combinational path from inputs to outputs.
- run = (state is COUNTDOWN or PLAY) && !pause.
- Second prescaler:
  - Counts 0..CLK_HZ-1 only while run.
  - Terminal count wraps to 0, and sec_tick is 1 in the following cycle.
  - The state and counter updates triggered by that terminal count land on the same edge, so they are visible alongside sec_tick.
  - The prescaler clears on entry to COUNTDOWN and on entry to PLAY.
- IDLE:
  - On start: go to COUNTDOWN next cycle.
  - Load countdown=COUNTDOWN_SEC and time_left=ROUND_SEC.
  - Latch level into lvl_q. Level changes during a round are ignored.
- COUNTDOWN:
  - Each terminal count decrements countdown.
  - At the terminal count with countdown==1: countdown→0 and go to PLAY.
- PLAY:
  - Each terminal count decrements time_left.
  - At the terminal count with time_left==1: time_left→0 and go to OVER.
  - Spawn counter counts 0..SPAWN_CYC(lvl_q)-1 while run, cleared on PLAY entry.
  - The spawn terminal count produces spawn_tick=1 the next cycle.
  - A spawn terminal count coinciding with the round-ending second terminal count is suppressed. No spawn_tick ever appears in OVER.
- OVER:
  - game_over=1.
  - time_left holds 0.
  - start → COUNTDOWN with the same reload as from IDLE.
- abort, any state: next state IDLE, counters cleared, countdown=0, time_left held.
- abort and start together: abort wins.
- start while in COUNTDOWN or PLAY: ignored.
- pause:
  - Freezes both counters and all state.
  - No sec_tick or spawn_tick is generated while paused.
  - Counting resumes from the frozen counts.
  - Ignored in IDLE and OVER.
- Arithmetic:
  - Counter widths come from $clog2 of the largest of CLK_HZ and the SPAWN_CYC_* values.
  - Decrements never underflow, because transitions occur at 1 rather than 0.

Decomposition:
- Package game_pkg:
  - state encoding constants: ST_IDLE, ST_COUNTDOWN, ST_PLAY, ST_OVER.
  - level-to-spawn-cycle lookup function.
  - Shared by the spawner and display blocks.
- Sub-module game_tick_gen:
  - Enable-gated, clearable prescaler with a runtime period input and registered one-cycle tick.
  - Instantiated twice: seconds and spawn.

Test Plan:
- Bench settings: CLK_HZ=10, ROUND_SEC=5, COUNTDOWN_SEC=3, SPAWN_CYC_L0..L3=8,6,4,2.
- Reset: hold rst=0 for 3 cycles with start=1 → state=0, all outputs 0. After release, start pulse → state=1, countdown=3, time_left=5.
- Full round at level 2:
  - First sec_tick 10 cycles after COUNTDOWN entry.
  - countdown steps 3,2,1,0, then PLAY after 30 cycles.
  - 12 spawn_ticks, every 4 cycles.
  - time_left reaches 0 and state=3 at PLAY cycle 50.
  - game_over=1.
- Level 3, collision case: spawn period 2 → 24 spawn_ticks. The spawn coinciding with the final second is suppressed, and spawn_tick=0 in OVER.
- Pause 17 cycles mid-PLAY: no ticks during the pause; the round end is delayed by exactly 17 cycles; time_left is unchanged while paused.
- abort and start asserted together in PLAY: state=0 next cycle, no further ticks. Then start in OVER after a completed round → COUNTDOWN, time_left reloads 5.
- Level changed from 0 to 3 during PLAY: spawn interval stays at 8 cycles until the next start.
